// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte-stream to command decoder with timeout and error pulses
//
// Purpose: assembles framed commands from a UART receiver byte stream.
//   Frames: AA addr data       -> type 0 (register write)
//           BB addr            -> type 1 (register read)
//           CC opA opB func    -> type 2 (ALU with operands)
//           DD func            -> type 3 (ALU without operands)
//   A completed frame is held on cmd_* with cmd_valid until cmd_ready.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   rx_data, rx_valid   - received byte and its one-cycle strobe
//   parity_error,
//   framing_error       - line errors qualifying the strobed byte
//   cmd_ready           - downstream accepts the held command
//   cmd_valid           - command held (high exactly in ISSUE)
//   cmd_type, cmd_addr,
//   cmd_data0, cmd_data1- decoded command fields, unused fields are 0
//   err_pulse           - one-cycle {timeout, overrun, bad_opcode, line_error}

module uart_cmd_decoder #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       parity_error,
    input  logic       framing_error,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_type,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data0,
    output logic [7:0] cmd_data1,
    output logic [3:0] err_pulse
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_D0   = 3'd2,
        GET_D1   = 3'd3,
        ISSUE    = 3'd4
    } state_t;

    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    localparam logic [3:0] ERR_LINE    = 4'b0001;
    localparam logic [3:0] ERR_OPCODE  = 4'b0010;
    localparam logic [3:0] ERR_OVERRUN = 4'b0100;
    localparam logic [3:0] ERR_TIMEOUT = 4'b1000;

    state_t      state, state_n;
    logic [1:0]  type_q, type_n;
    logic [7:0]  addr_q, addr_n;
    logic [7:0]  d0_q, d0_n;
    logic [7:0]  d1_q, d1_n;
    logic [15:0] idle_cnt, idle_cnt_n;
    logic [3:0]  err_q, err_n;

    logic        line_err;
    logic        byte_ok;

    assign line_err = parity_error | framing_error;
    assign byte_ok  = rx_valid & ~line_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            type_q   <= 2'd0;
            addr_q   <= 8'd0;
            d0_q     <= 8'd0;
            d1_q     <= 8'd0;
            idle_cnt <= 16'd0;
            err_q    <= 4'd0;
        end else begin
            state    <= state_n;
            type_q   <= type_n;
            addr_q   <= addr_n;
            d0_q     <= d0_n;
            d1_q     <= d1_n;
            idle_cnt <= idle_cnt_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        type_n     = type_q;
        addr_n     = addr_q;
        d0_n       = d0_q;
        d1_n       = d1_q;
        idle_cnt_n = 16'd0;
        err_n      = 4'd0;

        case (state)
            IDLE: begin
                if (rx_valid && line_err) begin
                    err_n = ERR_LINE;
                end else if (byte_ok) begin
                    // Clear every field up front so fields a type does not
                    // carry read as zero when the command is issued.
                    addr_n = 8'd0;
                    d0_n   = 8'd0;
                    d1_n   = 8'd0;
                    case (rx_data)
                        8'hAA: begin type_n = 2'd0; state_n = GET_ADDR; end
                        8'hBB: begin type_n = 2'd1; state_n = GET_ADDR; end
                        8'hCC: begin type_n = 2'd2; state_n = GET_D0;   end
                        8'hDD: begin type_n = 2'd3; state_n = GET_ADDR; end
                        default: begin
                            err_n  = ERR_OPCODE;
                            addr_n = addr_q;
                            d0_n   = d0_q;
                            d1_n   = d1_q;
                        end
                    endcase
                end
            end

            GET_ADDR, GET_D0, GET_D1: begin
                if (rx_valid) begin
                    if (line_err) begin
                        err_n   = ERR_LINE;
                        state_n = IDLE;
                    end else begin
                        case (state)
                            GET_ADDR: begin
                                addr_n  = rx_data;
                                state_n = (type_q == 2'd0) ? GET_D1 : ISSUE;
                            end
                            GET_D0: begin
                                d0_n    = rx_data;
                                state_n = GET_D1;
                            end
                            default: begin
                                // GET_D1 is operand B for ALU frames but the
                                // data slot of register writes.
                                if (type_q == 2'd2) begin
                                    d1_n    = rx_data;
                                    state_n = GET_ADDR;
                                end else begin
                                    d0_n    = rx_data;
                                    state_n = ISSUE;
                                end
                            end
                        endcase
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    err_n   = ERR_TIMEOUT;
                    state_n = IDLE;
                end else begin
                    idle_cnt_n = idle_cnt + 16'd1;
                end
            end

            ISSUE: begin
                if (rx_valid) begin
                    err_n = ERR_OVERRUN;
                end
                if (cmd_ready) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign cmd_valid = (state == ISSUE);
    assign cmd_type  = type_q;
    assign cmd_addr  = addr_q;
    assign cmd_data0 = d0_q;
    assign cmd_data1 = d1_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - self-checking bench for uart_cmd_decoder

module tb_uart_cmd_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       framing_error;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data0;
    logic [7:0] cmd_data1;
    logic [3:0] err_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    bit running = 0;

    uart_cmd_decoder #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_error(parity_error), .framing_error(framing_error),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_data0(cmd_data0), .cmd_data1(cmd_data1),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    // Frame-level model: bytes of the frame being assembled, cycles since the
    // last byte, and the command waiting for downstream.
    logic [7:0] fb[$];
    int         gap;
    bit         holding;
    logic [1:0] h_type;
    logic [7:0] h_addr, h_d0, h_d1;
    logic [3:0] exp_err;

    function automatic int frame_len(input logic [7:0] op);
        case (op)
            8'hAA: return 3;
            8'hCC: return 4;
            default: return 2;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fb.delete();
            gap = 0;
            holding = 0;
            exp_err = 4'd0;
            h_type = 0; h_addr = 0; h_d0 = 0; h_d1 = 0;
        end else begin
            exp_err = 4'd0;
            if (holding) begin
                if (rx_valid) exp_err = 4'b0100;
                if (cmd_ready) holding = 0;
            end else if (rx_valid) begin
                gap = 0;
                if (parity_error || framing_error) begin
                    exp_err = 4'b0001;
                    fb.delete();
                end else if (fb.size() == 0 &&
                             !(rx_data inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) begin
                    exp_err = 4'b0010;
                end else begin
                    fb.push_back(rx_data);
                    if (fb.size() == frame_len(fb[0])) begin
                        h_addr = 0; h_d0 = 0; h_d1 = 0;
                        case (fb[0])
                            8'hAA: begin h_type = 0; h_addr = fb[1]; h_d0 = fb[2]; end
                            8'hBB: begin h_type = 1; h_addr = fb[1]; end
                            8'hCC: begin h_type = 2; h_d0 = fb[1]; h_d1 = fb[2]; h_addr = fb[3]; end
                            default: begin h_type = 3; h_addr = fb[1]; end
                        endcase
                        holding = 1;
                        fb.delete();
                    end
                end
            end else if (fb.size() > 0) begin
                gap++;
                if (gap == TO) begin
                    exp_err = 4'b1000;
                    fb.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            n_cmp++;
            if (cmd_valid !== holding || err_pulse !== exp_err) begin
                n_bad++;
                $display("FAIL cycle_check t=%0t: cmd_valid=%b err_pulse=%b, required cmd_valid=%b err_pulse=%b",
                         $time, cmd_valid, err_pulse, holding, exp_err);
            end
            if (holding) begin
                n_cmp++;
                if ({cmd_type, cmd_addr, cmd_data0, cmd_data1} !== {h_type, h_addr, h_d0, h_d1}) begin
                    n_bad++;
                    $display("FAIL cmd_fields t=%0t: got %0d/%h/%h/%h, required %0d/%h/%h/%h",
                             $time, cmd_type, cmd_addr, cmd_data0, cmd_data1,
                             h_type, h_addr, h_d0, h_d1);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic fe = 1'b0);
        rx_data = b; parity_error = pe; framing_error = fe; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
    endtask

    task automatic chk_cmd(input string name, input logic [1:0] t, input logic [7:0] a,
                           input logic [7:0] d0, input logic [7:0] d1);
        chk({name, "_valid"}, {31'd0, cmd_valid}, 32'd1);
        chk({name, "_fields"}, {8'd0, 6'd0, cmd_type, cmd_addr, cmd_data0, cmd_data1},
            {8'd0, 6'd0, t, a, d0, d1});
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        parity_error = 1'b0; framing_error = 1'b0; cmd_ready = 1'b1;
        tick(2);
        chk("reset_state", {cmd_valid, err_pulse, cmd_type, cmd_addr, cmd_data0, cmd_data1},
            32'd0);
        running = 1;
        reset = 1'b0;
        tick(2);

        // Register write, downstream ready.
        send(8'hAA); send(8'h05); send(8'h3C);
        chk_cmd("wr", 2'd0, 8'h05, 8'h3C, 8'h00);
        tick(1);
        chk("wr_drop", {31'd0, cmd_valid}, 32'd0);

        // ALU with operands held under back-pressure for 11 cycles.
        cmd_ready = 1'b0;
        send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
        for (int i = 0; i < 10; i++) begin
            chk_cmd("alu_hold", 2'd2, 8'h02, 8'h12, 8'h34);
            tick(1);
        end
        cmd_ready = 1'b1;
        chk_cmd("alu_last", 2'd2, 8'h02, 8'h12, 8'h34);
        tick(1);
        chk("alu_drop", {31'd0, cmd_valid}, 32'd0);

        // Parity error discards a read frame; next frame decodes cleanly.
        send(8'hBB); send(8'h57, 1'b1, 1'b0);
        chk("parity_err", {28'd0, err_pulse}, 32'h1);
        tick(1);
        chk("parity_err_clear", {27'd0, cmd_valid, err_pulse}, 32'd0);
        send(8'hDD); send(8'h08);
        chk_cmd("alu_noop", 2'd3, 8'h08, 8'h00, 8'h00);
        tick(2);

        // Framing error in the middle of an ALU frame.
        send(8'hCC); send(8'h01); send(8'h02, 1'b0, 1'b1);
        chk("framing_err", {28'd0, err_pulse}, 32'h1);
        tick(3);

        // Timeout: error registered on the 16th edge after the AA strobe.
        send(8'hAA);
        tick(TO - 1);
        chk("no_timeout_yet", {28'd0, err_pulse}, 32'h0);
        tick(1);
        chk("timeout", {28'd0, err_pulse}, 32'h8);
        tick(1);
        send(8'h05);
        chk("after_timeout_idle", {28'd0, err_pulse}, 32'h2);

        // Byte strobed 15 cycles after AA keeps the frame alive.
        send(8'hAA); tick(TO - 2); send(8'h05); tick(3); send(8'h3C);
        chk_cmd("late15", 2'd0, 8'h05, 8'h3C, 8'h00);
        tick(2);

        // Byte on the very cycle the counter is at its last value wins.
        send(8'hAA); tick(TO - 1); send(8'h06); send(8'h7F);
        chk_cmd("late16", 2'd0, 8'h06, 8'h7F, 8'h00);
        tick(2);

        // Bad opcode, then overrun while holding and on the transfer cycle.
        send(8'h7E);
        chk("bad_opcode", {28'd0, err_pulse}, 32'h2);
        cmd_ready = 1'b0;
        send(8'hBB); send(8'h11);
        tick(2);
        send(8'h99);
        chk("overrun", {28'd0, err_pulse}, 32'h4);
        chk_cmd("overrun_hold", 2'd1, 8'h11, 8'h00, 8'h00);
        cmd_ready = 1'b1;
        send(8'h44);
        chk("overrun_xfer", {27'd0, cmd_valid, err_pulse}, 32'h4);
        tick(2);

        // Reset mid-frame and in ISSUE.
        send(8'hAA); send(8'h05);
        reset = 1'b1; #1;
        chk("reset_mid", {cmd_valid, err_pulse, cmd_type, cmd_addr, cmd_data0, cmd_data1}, 32'd0);
        tick(1); reset = 1'b0; tick(2);
        send(8'hBB); send(8'h09);
        chk_cmd("after_reset", 2'd1, 8'h09, 8'h00, 8'h00);
        tick(2);
        cmd_ready = 1'b0;
        send(8'hDD); send(8'h31);
        reset = 1'b1; #1;
        chk("reset_issue", {31'd0, cmd_valid}, 32'd0);
        tick(1); reset = 1'b0; cmd_ready = 1'b1; tick(2);
        send(8'hBB); send(8'h0A);
        chk_cmd("after_reset2", 2'd1, 8'h0A, 8'h00, 8'h00);
        tick(3);

        running = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter: TIMEOUT, 1024, idle cycles allowed between bytes of one frame (range 2..65535).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: rx_data  input  8  received byte from the UART receiver.
REQ-005 SHALL have port: rx_valid  input  1  one-cycle strobe, rx_data/parity_error/framing_error valid.
REQ-006 SHALL have port: parity_error  input  1  parity error of the strobed byte.
REQ-007 SHALL have port: framing_error  input  1  stop-bit error of the strobed byte.
REQ-008 SHALL have port: cmd_ready  input  1  downstream accepts the command.
REQ-009 SHALL have port: cmd_valid  output  1  decoded command available.
REQ-010 SHALL have port: cmd_type  output  2  0 reg write, 1 reg read, 2 ALU with operands, 3 ALU without operands.
REQ-011 SHALL have port: cmd_addr  output  8  register address (types 0/1) or ALU function (types 2/3).
REQ-012 SHALL have port: cmd_data0  output  8  write data (type 0) or operand A (type 2), else 0.
REQ-013 SHALL have port: cmd_data1  output  8  operand B (type 2), else 0.
REQ-014 SHALL have port: err_pulse  output  4  one-cycle flags {timeout, overrun, bad_opcode, line_error}, bit3..bit0.

Function
REQ-015 SHALL implement states IDLE, GET_ADDR, GET_D0, GET_D1, ISSUE.
REQ-016 SHALL accept a byte only on a cycle with rx_valid=1; an accepted byte is one with rx_valid=1 and parity_error=0 and framing_error=0.
REQ-017 IDLE, accepted 0xAA -> GET_ADDR, type 0; 0xBB -> GET_ADDR, type 1; 0xCC -> GET_D0, type 2; 0xDD -> GET_ADDR, type 3.
REQ-018 IDLE, any other accepted byte -> stay IDLE, err_pulse[1]=1 for one cycle.
REQ-019 GET_ADDR: byte latched into cmd_addr; type 0 -> GET_D1 (data slot), types 1/3 -> ISSUE.
REQ-020 Type 0 data byte SHALL be latched into cmd_data0, then -> ISSUE.
REQ-021 Type 2 SHALL collect operand A (cmd_data0), operand B (cmd_data1), function (cmd_addr), in that order, then -> ISSUE.
REQ-022 Fields not carried by a command type SHALL be 0 while cmd_valid=1.
REQ-023 cmd_valid SHALL rise on the cycle after the final byte's rx_valid and be high exactly in ISSUE.
REQ-024 cmd_type/addr/data0/data1 SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-025 Transfer occurs on the cycle with cmd_valid=1 and cmd_ready=1; next state IDLE, cmd_valid=0 next cycle.
REQ-026 rx_valid in ISSUE (including the transfer cycle) SHALL be dropped, err_pulse[2]=1 for one cycle, outputs unchanged.
REQ-027 rx_valid with parity_error or framing_error in any non-ISSUE state SHALL set err_pulse[0]=1 and go IDLE, partial frame discarded.
REQ-028 In GET_ADDR/GET_D0/GET_D1 a 16-bit idle counter SHALL clear on each rx_valid and increment otherwise.
REQ-029 If the counter equals TIMEOUT-1 and rx_valid=0, SHALL go IDLE with err_pulse[3]=1 (abort TIMEOUT cycles after last byte); rx_valid on that same cycle wins and is processed normally.
REQ-030 Idle counter SHALL be held at 0 in IDLE and ISSUE.
REQ-031 err_pulse bits SHALL be registered, each high for exactly one cycle per event; at most one bit per cycle.

Reset
REQ-032 While reset=1: state IDLE, cmd_valid=0, cmd_type/addr/data0/data1=0, err_pulse=0, idle counter=0, asynchronously.
REQ-033 Reset asserted mid-frame or in ISSUE SHALL discard the frame; first rx_valid after release is decoded as an opcode.

Verification
REQ-034 Bytes AA,05,3C, cmd_ready=1 -> one cycle after 3C: cmd_valid=1, type 0, addr 05, data0 3C, data1 00; low next cycle.
REQ-035 Bytes CC,12,34,02, cmd_ready=0 for 10 cycles then 1 -> cmd_valid held 11 cycles, type 2, addr 02, data0 12, data1 34 stable throughout.
REQ-036 Bytes BB then 57 with parity_error=1 -> err_pulse=0001 one cycle, no cmd_valid; then DD,08 -> type 3, addr 08.
REQ-037 TIMEOUT=16, byte AA then silence -> err_pulse=1000 exactly 16 cycles after AA strobe, state IDLE; byte at cycle 15 instead -> no timeout.
REQ-038 Byte 7E in IDLE -> err_pulse=0010; byte during ISSUE -> err_pulse=0100, held command unchanged.
REQ-039 reset pulse after AA,05 -> cmd_valid never asserts; subsequent BB,09 -> type 1, addr 09.
